// File: rtl/hue_pkg.sv
// Shared types for the hue sequencer: hue phase encoding, ramp descriptor and phase helpers.
package hue_pkg;

  localparam int unsigned PHASE_COUNT = 6;
  localparam int unsigned PHASE_W     = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_G_UP = 3'd0,
    PH_R_DN = 3'd1,
    PH_B_UP = 3'd2,
    PH_G_DN = 3'd3,
    PH_R_UP = 3'd4,
    PH_B_DN = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  typedef struct packed {
    chan_e ch;
    logic  rising;
  } ramp_t;

  // Which channel moves in a given phase, and in which direction.
  function automatic ramp_t ramp_of(input phase_e p);
    ramp_t r;
    r = '{ch: CH_R, rising: 1'b0};
    case (p)
      PH_G_UP: r = '{ch: CH_G, rising: 1'b1};
      PH_R_DN: r = '{ch: CH_R, rising: 1'b0};
      PH_B_UP: r = '{ch: CH_B, rising: 1'b1};
      PH_G_DN: r = '{ch: CH_G, rising: 1'b0};
      PH_R_UP: r = '{ch: CH_R, rising: 1'b1};
      PH_B_DN: r = '{ch: CH_B, rising: 1'b0};
      default: r = '{ch: CH_R, rising: 1'b0};
    endcase
    return r;
  endfunction

  function automatic phase_e phase_next(input phase_e p);
    if (p == phase_e'(PHASE_W'(PHASE_COUNT - 1))) begin
      return PH_G_UP;
    end
    return phase_e'(p + PHASE_W'(1));
  endfunction

endpackage

// File: rtl/hue_sequencer_period_timer.sv
// PWM period counter plus step counter; emits the period_start pulse and the duty update strobe.
module period_timer #(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned STEP_PERIODS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic period_start,
  output logic update_c
);

  localparam int unsigned PW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam int unsigned SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  logic [PW-1:0] period_cnt_q, period_cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic          period_start_q, period_start_d;
  logic          last_cycle_c;
  logic          step_adv_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt_q   <= '0;
      step_cnt_q     <= '0;
      period_start_q <= 1'b1;
    end else begin
      period_cnt_q   <= period_cnt_d;
      step_cnt_q     <= step_cnt_d;
      period_start_q <= period_start_d;
    end
  end

  // Period counter free-runs; step counter only moves on enabled period ends.
  always_comb begin
    last_cycle_c   = (period_cnt_q == PW'(PWM_INTERVAL - 1));
    period_cnt_d   = last_cycle_c ? '0 : period_cnt_q + PW'(1);
    step_adv_c     = last_cycle_c & enable;
    step_cnt_d     = step_cnt_q;
    update_c       = 1'b0;
    if (step_adv_c) begin
      if (step_cnt_q == SW'(STEP_PERIODS - 1)) begin
        step_cnt_d = '0;
        update_c   = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + SW'(1);
      end
    end
    period_start_d = (period_cnt_d == '0);
  end

  assign period_start = period_start_q;

endmodule

// File: rtl/hue_sequencer.sv
// Colour-wheel sequencer: ramps one RGB duty value at a time through six hue phases.
module hue_sequencer
  import hue_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned STEP_SIZE    = 12,
  parameter int unsigned STEP_PERIODS = 100
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  output logic [$clog2(PWM_INTERVAL)-1:0]   pwm_valueR,
  output logic [$clog2(PWM_INTERVAL)-1:0]   pwm_valueG,
  output logic [$clog2(PWM_INTERVAL)-1:0]   pwm_valueB,
  output logic                              period_start,
  output logic [2:0]                        phase
);

  localparam int unsigned DW = $clog2(PWM_INTERVAL);
  localparam int unsigned EW = DW + 1;
  localparam logic [EW-1:0] MAX_E  = EW'(PWM_INTERVAL);
  localparam logic [EW-1:0] STEP_E = EW'(STEP_SIZE);

  logic [DW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  phase_e        phase_q, phase_d;
  logic          update_c;
  ramp_t         ramp_c;
  logic [EW-1:0] cur_c, sum_c, nxt_c;
  logic          at_end_c;

  period_timer #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .STEP_PERIODS (STEP_PERIODS)
  ) u_period_timer (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .period_start (period_start),
    .update_c     (update_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= DW'(PWM_INTERVAL);
      g_q     <= '0;
      b_q     <= '0;
      phase_q <= PH_G_UP;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      phase_q <= phase_d;
    end
  end

  // Saturating step of the ramping channel, computed one bit wider than the duty registers.
  always_comb begin
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    phase_d  = phase_q;
    ramp_c   = ramp_of(phase_q);
    case (ramp_c.ch)
      CH_G:    cur_c = {1'b0, g_q};
      CH_B:    cur_c = {1'b0, b_q};
      default: cur_c = {1'b0, r_q};
    endcase
    sum_c    = cur_c + STEP_E;
    nxt_c    = cur_c;
    at_end_c = 1'b0;
    if (ramp_c.rising) begin
      nxt_c    = (sum_c >= MAX_E) ? MAX_E : sum_c;
      at_end_c = (nxt_c == MAX_E);
    end else begin
      nxt_c    = (cur_c <= STEP_E) ? '0 : cur_c - STEP_E;
      at_end_c = (nxt_c == '0);
    end
    if (update_c) begin
      case (ramp_c.ch)
        CH_G:    g_d = DW'(nxt_c);
        CH_B:    b_d = DW'(nxt_c);
        default: r_d = DW'(nxt_c);
      endcase
      if (at_end_c) begin
        phase_d = phase_next(phase_q);
      end
    end
  end

  always_comb begin
    pwm_valueR = r_q;
    pwm_valueG = g_q;
    pwm_valueB = b_q;
    phase      = phase_q;
  end

endmodule
